// File: rtl/eecd_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : eecd_pkg                                                      |
// | Brief    : Shared stream-link constants, request layout and FSM states.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package eecd_pkg;

    localparam logic [63:0] AXI_REQ_MAGIC = 64'hBEADCAFEFADEDBAD;
    localparam int          ROW_CYCLES    = 34;
    localparam int          BEAT_WIDTH    = 512;

    localparam int REQ_WIDTH    = 72;
    localparam int REQ_DATA_LSB = 0;
    localparam int REQ_ADDR_LSB = 32;
    localparam int REQ_TYPE_LSB = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_REQ  = 2'd2
    } state_e;

    // Both 32-bit halves of the top word are equal, so a data beat never aliases the magic.
    function automatic logic [BEAT_WIDTH-1:0] data_beat(input logic [31:0] seq);
        return {16{seq}};
    endfunction

    function automatic logic [BEAT_WIDTH-1:0] req_beat(input logic [REQ_WIDTH-1:0] req);
        return {AXI_REQ_MAGIC,
                {(BEAT_WIDTH-64-REQ_WIDTH){1'b0}},
                req[REQ_TYPE_LSB +: 8],
                req[REQ_ADDR_LSB +: 32],
                req[REQ_DATA_LSB +: 32]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_row_producer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : axis_row_producer                                             |
// | Brief    : Row traffic generator with interleaved tagged request beats.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module axis_row_producer #(
    parameter int DATA_WIDTH = 512,
    parameter int ROW_CYCLES = eecd_pkg::ROW_CYCLES
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            start,
    input  logic [31:0]                     row_count,
    output logic                            busy,
    output logic                            row_complete,
    output logic [31:0]                     rows_sent,
    input  logic [eecd_pkg::REQ_WIDTH-1:0]  AXI_REQ_TDATA,
    input  logic                            AXI_REQ_TVALID,
    output logic                            AXI_REQ_TREADY,
    output logic [DATA_WIDTH-1:0]           AXIS_TDATA,
    output logic                            AXIS_TVALID,
    input  logic                            AXIS_TREADY
);
    import eecd_pkg::*;

    localparam int                    BEAT_CNT_W  = $clog2(ROW_CYCLES);
    localparam logic [BEAT_CNT_W-1:0] c_last_beat = BEAT_CNT_W'(ROW_CYCLES - 1);

    state_e                  r_state, w_state_next;
    logic [BEAT_CNT_W-1:0]   r_beat, w_beat_next;
    logic [31:0]             r_seq, w_seq_next;
    logic [31:0]             r_count, w_count_next;
    logic [31:0]             r_rows_sent, w_rows_sent_next;
    logic                    r_busy, w_busy_next;
    logic                    r_row_complete, w_row_complete_next;
    logic                    r_tvalid, w_tvalid_next;
    logic [DATA_WIDTH-1:0]   r_tdata, w_tdata_next;

    logic                    w_accept;
    logic                    w_last_beat;
    logic [31:0]             w_rows_inc;
    logic                    w_run_done;

    assign w_accept    = r_tvalid && AXIS_TREADY;
    assign w_last_beat = (r_beat == c_last_beat);
    assign w_rows_inc  = r_rows_sent + 32'd1;
    assign w_run_done  = (w_rows_inc == r_count);

    // Requests are only taken between rows: in IDLE, or as the final beat of a non-final row leaves.
    assign AXI_REQ_TREADY = resetn &&
                            ((r_state == ST_IDLE) ||
                             ((r_state == ST_DATA) && w_accept && w_last_beat && !w_run_done));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state        <= ST_IDLE;
            r_beat         <= '0;
            r_seq          <= '0;
            r_count        <= '0;
            r_rows_sent    <= '0;
            r_busy         <= 1'b0;
            r_row_complete <= 1'b0;
            r_tvalid       <= 1'b0;
            r_tdata        <= '0;
        end else begin
            r_state        <= w_state_next;
            r_beat         <= w_beat_next;
            r_seq          <= w_seq_next;
            r_count        <= w_count_next;
            r_rows_sent    <= w_rows_sent_next;
            r_busy         <= w_busy_next;
            r_row_complete <= w_row_complete_next;
            r_tvalid       <= w_tvalid_next;
            r_tdata        <= w_tdata_next;
        end
    end

    always_comb begin
        w_state_next        = r_state;
        w_beat_next         = r_beat;
        w_seq_next          = r_seq;
        w_count_next        = r_count;
        w_rows_sent_next    = r_rows_sent;
        w_busy_next         = r_busy;
        w_row_complete_next = 1'b0;
        w_tvalid_next       = r_tvalid;
        w_tdata_next        = r_tdata;

        case (r_state)
            ST_IDLE: begin
                if (AXI_REQ_TVALID) begin
                    w_tdata_next  = req_beat(AXI_REQ_TDATA);
                    w_tvalid_next = 1'b1;
                    w_state_next  = ST_REQ;
                end else if (start && (row_count != 32'd0)) begin
                    w_count_next     = row_count;
                    w_rows_sent_next = '0;
                    w_seq_next       = '0;
                    w_beat_next      = '0;
                    w_tdata_next     = data_beat(32'd0);
                    w_tvalid_next    = 1'b1;
                    w_busy_next      = 1'b1;
                    w_state_next     = ST_DATA;
                end
            end

            ST_DATA: begin
                if (w_accept) begin
                    w_seq_next = r_seq + 32'd1;
                    if (!w_last_beat) begin
                        w_beat_next  = r_beat + BEAT_CNT_W'(1);
                        w_tdata_next = data_beat(r_seq + 32'd1);
                    end else begin
                        w_beat_next         = '0;
                        w_row_complete_next = 1'b1;
                        w_rows_sent_next    = w_rows_inc;
                        if (w_run_done) begin
                            w_tvalid_next = 1'b0;
                            w_tdata_next  = '0;
                            w_busy_next   = 1'b0;
                            w_state_next  = ST_IDLE;
                        end else if (AXI_REQ_TVALID) begin
                            w_tdata_next = req_beat(AXI_REQ_TDATA);
                            w_state_next = ST_REQ;
                        end else begin
                            w_tdata_next = data_beat(r_seq + 32'd1);
                        end
                    end
                end
            end

            ST_REQ: begin
                // busy distinguishes a request slipped between rows from one taken while idle.
                if (w_accept) begin
                    if (r_busy) begin
                        w_tdata_next = data_beat(r_seq);
                        w_state_next = ST_DATA;
                    end else begin
                        w_tvalid_next = 1'b0;
                        w_tdata_next  = '0;
                        w_state_next  = ST_IDLE;
                    end
                end
            end

            default: begin
                w_tvalid_next = 1'b0;
                w_busy_next   = 1'b0;
                w_state_next  = ST_IDLE;
            end
        endcase
    end

    assign busy         = r_busy;
    assign row_complete = r_row_complete;
    assign rows_sent    = r_rows_sent;
    assign AXIS_TVALID  = r_tvalid;
    assign AXIS_TDATA   = r_tdata;

endmodule
`default_nettype wire

// File: tb/tb_axis_row_producer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_axis_row_producer                                          |
// | Brief    : Scoreboard bench for axis_row_producer.                       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_axis_row_producer;

    localparam logic [63:0] c_magic = 64'hBEADCAFEFADEDBAD;

    logic         clk = 1'b0;
    logic         resetn;
    logic         start;
    logic [31:0]  row_count;
    logic         busy;
    logic         row_complete;
    logic [31:0]  rows_sent;
    logic [71:0]  req_tdata;
    logic         req_tvalid;
    logic         req_tready;
    logic [511:0] axis_tdata;
    logic         axis_tvalid;
    logic         axis_tready;

    int checks   = 0;
    int failures = 0;

    logic [511:0] exp_q[$];
    int           row_len  = 0;
    int           rc_total = 0;
    logic         prev_stall = 1'b0;
    logic [511:0] prev_data  = '0;

    axis_row_producer #(.DATA_WIDTH(512), .ROW_CYCLES(34)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .start          (start),
        .row_count      (row_count),
        .busy           (busy),
        .row_complete   (row_complete),
        .rows_sent      (rows_sent),
        .AXI_REQ_TDATA  (req_tdata),
        .AXI_REQ_TVALID (req_tvalid),
        .AXI_REQ_TREADY (req_tready),
        .AXIS_TDATA     (axis_tdata),
        .AXIS_TVALID    (axis_tvalid),
        .AXIS_TREADY    (axis_tready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] model_data(input logic [31:0] s);
        return {16{s}};
    endfunction

    function automatic logic [511:0] model_req(input logic [7:0] t, input logic [31:0] a,
                                               input logic [31:0] d);
        logic [511:0] b;
        b = '0;
        b[511:448] = c_magic;
        b[71:64]   = t;
        b[63:32]   = a;
        b[31:0]    = d;
        return b;
    endfunction

    task automatic push_seq(input int first, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(model_data(32'(first + i)));
    endtask

    // Monitor: handshakes seen at the negedge complete on the following posedge.
    always @(negedge clk) begin
        if (!resetn) begin
            prev_stall = 1'b0;
            row_len    = 0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", {511'd0, axis_tvalid}, 512'd1);
                chk("hold_data", axis_tdata, prev_data);
            end
            if (row_complete) begin
                chk("row_len", 512'(row_len), 512'd34);
                row_len = 0;
                rc_total++;
            end
            if (axis_tvalid && axis_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", axis_tdata, 512'd0);
                    if (axis_tdata === 512'd0) begin
                        failures++;
                        $display("FAIL unexpected_beat actual=0 required=none");
                    end
                end else begin
                    chk("beat", axis_tdata, exp_q.pop_front());
                end
                if (axis_tdata[511:448] !== c_magic) row_len++;
            end
            prev_stall = axis_tvalid && !axis_tready;
            prev_data  = axis_tdata;
        end
    end

    task automatic pulse_start(input logic [31:0] cnt);
        row_count = cnt;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) chk("idle_timeout", {511'd0, busy}, 512'd0);
    endtask

    int n, m;

    initial begin
        resetn      = 1'b0;
        start       = 1'b0;
        row_count   = '0;
        req_tdata   = '0;
        req_tvalid  = 1'b0;
        axis_tready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", {511'd0, axis_tvalid}, 512'd0);
        chk("rst_tdata", axis_tdata, 512'd0);
        chk("rst_busy", {511'd0, busy}, 512'd0);
        chk("rst_rc", {511'd0, row_complete}, 512'd0);
        chk("rst_rows", 512'(rows_sent), 512'd0);
        chk("rst_reqrdy", {511'd0, req_tready}, 512'd0);
        resetn = 1'b1;
        @(posedge clk); #1;
        chk("idle_reqrdy", {511'd0, req_tready}, 512'd1);

        // Two rows back to back at full rate
        push_seq(0, 68);
        pulse_start(32'd2);
        chk("t1_busy_n1", {511'd0, busy}, 512'd1);
        chk("t1_valid_n1", {511'd0, axis_tvalid}, 512'd1);
        wait_idle(n);
        chk("t1_cycles", 512'(n), 512'd68);
        chk("t1_rows", 512'(rows_sent), 512'd2);
        chk("t1_valid_end", {511'd0, axis_tvalid}, 512'd0);

        // One row under random backpressure
        push_seq(0, 34);
        pulse_start(32'd1);
        n = 0;
        while (busy && n < 1000) begin
            axis_tready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
        if (busy) chk("t2_timeout", {511'd0, busy}, 512'd0);
        axis_tready = 1'b1;
        chk("t2_rows", 512'(rows_sent), 512'd1);

        // Request held during row 0 of 2: slotted in between the rows
        push_seq(0, 34);
        exp_q.push_back(model_req(8'h00, 32'h0000_1000, 32'hDEAD_BEEF));
        push_seq(34, 34);
        pulse_start(32'd2);
        req_tdata  = {8'h00, 32'h0000_1000, 32'hDEAD_BEEF};
        req_tvalid = 1'b1;
        n = 0;
        while (!req_tready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("t3_req_slot", 512'(n), 512'd33);
        @(posedge clk); #1;
        req_tvalid = 1'b0;
        wait_idle(m);
        chk("t3_cycles", 512'(n + 1 + m), 512'd69);
        chk("t3_rows", 512'(rows_sent), 512'd2);

        // Request and start together in IDLE: request wins, start is lost
        exp_q.push_back(model_req(8'h02, 32'h0000_2000, 32'h1234_5678));
        req_tdata  = {8'h02, 32'h0000_2000, 32'h1234_5678};
        req_tvalid = 1'b1;
        pulse_start(32'd3);
        req_tvalid = 1'b0;
        chk("t4_req_valid", {511'd0, axis_tvalid}, 512'd1);
        m = 0;
        for (int i = 0; i < 6; i++) begin
            if (busy) m++;
            @(posedge clk); #1;
        end
        chk("t4_busy_cycles", 512'(m), 512'd0);
        chk("t4_valid_end", {511'd0, axis_tvalid}, 512'd0);
        push_seq(0, 34);
        pulse_start(32'd1);
        wait_idle(n);
        chk("t4_rerun_cycles", 512'(n), 512'd34);
        chk("t4_rows", 512'(rows_sent), 512'd1);

        // Zero-length start ignored; start while busy ignored
        pulse_start(32'd0);
        m = 0;
        for (int i = 0; i < 5; i++) begin
            if (busy || axis_tvalid) m++;
            @(posedge clk); #1;
        end
        chk("t5_zero_activity", 512'(m), 512'd0);
        push_seq(0, 34);
        pulse_start(32'd1);
        repeat (5) @(posedge clk);
        #1;
        pulse_start(32'd5);
        wait_idle(n);
        chk("t5_cycles", 512'(n + 6), 512'd34);
        chk("t5_rows", 512'(rows_sent), 512'd1);

        // Reset mid-row, then a fresh run
        push_seq(0, 10);
        pulse_start(32'd2);
        repeat (10) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        chk("t6_tvalid", {511'd0, axis_tvalid}, 512'd0);
        chk("t6_tdata", axis_tdata, 512'd0);
        chk("t6_busy", {511'd0, busy}, 512'd0);
        chk("t6_rows", 512'(rows_sent), 512'd0);
        chk("t6_reqrdy", {511'd0, req_tready}, 512'd0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        push_seq(0, 34);
        pulse_start(32'd1);
        wait_idle(n);
        chk("t6_rerun_cycles", 512'(n), 512'd34);
        chk("t6_rerun_rows", 512'(rows_sent), 512'd1);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", 512'(exp_q.size()), 512'd0);
        chk("rc_total", 512'(rc_total), 512'd8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
